param_updown_counter: RTL and testbench
=======================================

Name: param_updown_counter

Overview:
Parametrised synchronous up/down counter, the generalised successor to the fixed 4-bit up/down counter. It adds configurable width and modulus, and selectable wrap or saturate mode. It also adds count enable, synchronous parallel load, a terminal-count flag and a registered overflow/underflow pulse. It is the shared counting primitive for timers, dividers and address generators in the design.

Parameters:
WIDTH, 4, counter width in bits (1..32).
MAX_COUNT, 2**WIDTH-1, highest legal count; the counter runs over 0..MAX_COUNT (modulus MAX_COUNT+1). Must be at most 2**WIDTH-1.
SATURATE, 0, 0 = wrap at the bounds, 1 = hold at the bounds.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
reset_n  input  1  asynchronous, active-low reset.
en  input  1  count enable.
up_down  input  1  1 = count up, 0 = count down.
load  input  1  synchronous parallel load.
load_value  input  WIDTH  value to load.
count  output  WIDTH  current count, registered.
tc  output  1  terminal count, combinational.
ovf  output  1  one-cycle overflow/underflow pulse, registered.

Behaviour:
- Reset: reset_n low forces count=0 and ovf=0 immediately, without waiting for a clock edge. The first update happens on the first rising clk edge after reset_n goes high.
- Priority per edge: load, then en, then hold.
- load=1: count <= min(load_value, MAX_COUNT); ovf <= 0. Load overrides en and up_down in the same cycle.
- en=1, up_down=1, count<MAX_COUNT: count <= count+1; ovf <= 0.
- en=1, up_down=1, count==MAX_COUNT: wrap mode gives count <= 0; saturate mode holds at MAX_COUNT. ovf <= 1 in both modes.
- en=1, up_down=0, count>0: count <= count-1; ovf <= 0.
- en=1, up_down=0, count==0: wrap mode gives count <= MAX_COUNT; saturate mode holds at 0. ovf <= 1 in both modes.
- en=0, load=0: count holds; ovf <= 0.
- Latency: count reflects a load or step one edge after the inputs are sampled. ovf is asserted during the cycle in which the count shows the post-boundary value (or the held value in saturate mode).
- tc = en & ~load & ((up_down & count==MAX_COUNT) | (~up_down & count==0)). tc is high exactly in the cycle before the edge that raises ovf, which makes it usable for cascading.
- Arithmetic is performed at WIDTH bits. Out-of-range states cannot be reached, because load clamps and reset clears.
- up_down may change on any cycle. Direction takes effect on the next enabled edge with no extra latency.
- If reset_n is asserted mid-count, count and ovf clear at once. Load and en are ignored while reset_n is low.
- MAX_COUNT=0 is legal: count stays at 0, tc=en&~load, and ovf pulses on every enabled edge.

Decomposition:
- Shared package counter_pkg: mode constants MODE_WRAP=0 and MODE_SAT=1, plus a next-count function next_count(count, up_down, max, sat).
- Single module. No sub-module is needed; the next-state logic is one combinational block, and the register process holds count and ovf.

Test Plan:
(Configuration for all scenarios: WIDTH=4, MAX_COUNT=9, SATURATE=0 unless stated.)
1. Reset: hold reset_n=0 with en=1 across 3 edges, then deassert between edges -> count=0 and ovf=0 throughout; count=1 after the first subsequent up edge.
2. Up wrap: en=1, up_down=1 from 0 for 12 edges -> 0..9,0,1,2; tc=1 while count=9; ovf=1 only in the cycle count=0 after 9.
3. Down wrap: load 2, then up_down=0 for 4 edges -> 2,1,0,9,8; tc=1 while count=0; ovf pulses with the count at 9.
4. Saturate (SATURATE=1): count up from 7 for 5 edges -> 8,9,9,9,9 with ovf=1 on each edge held at 9; down from 1 for 3 edges -> 0,0,0.
5. Load priority and clamp: load=1, load_value=13, en=1, up_down=1 -> count=9 and ovf=0; load_value=5 with en=0 -> count=5; en=0 with load=0 for 4 edges -> holds at 5.
6. Direction change and async reset: counting up at 4, flip up_down each edge -> 5,4,5,4; pulse reset_n low mid-cycle -> count=0 immediately, before the next edge.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared definitions for the up/down counting primitive: counting modes and
// the next-count rule used by every counter instance.
package counter_pkg;

   localparam bit MODE_WRAP = 1'b0;
   localparam bit MODE_SAT  = 1'b1;

   // Next value of an enabled count step. Values are zero-extended to 32 bits
   // so one function serves every counter width; the caller truncates.
   function automatic logic [31:0] next_count(input logic [31:0] count,
                                              input logic        up_down,
                                              input logic [31:0] max,
                                              input logic        sat);
      logic [31:0] result;
      if (up_down) begin
         if (count >= max) result = sat ? max : 32'd0;
         else              result = count + 32'd1;
      end else begin
         if (count == 32'd0) result = sat ? 32'd0 : max;
         else                result = count - 32'd1;
      end
      return result;
   endfunction

endpackage

// File: rtl/param_updown_counter.sv
// Parametrised up/down counter with wrap or saturate mode, enable,
// synchronous load with clamping, terminal-count flag and overflow pulse.
module param_updown_counter
   import counter_pkg::*;
#(
   parameter int          WIDTH     = 4,
   parameter int unsigned MAX_COUNT = 2**WIDTH - 1,
   parameter bit          SATURATE  = MODE_WRAP
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             en,
   input  logic             up_down,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             ovf
);

   localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX_COUNT);
   localparam bit               SAT_ON  = (SATURATE == MODE_SAT);

   logic [WIDTH-1:0] count_d;
   logic             ovf_d;
   logic             at_bound;
   logic [WIDTH-1:0] load_clamped;

   // The boundary depends on direction: top when counting up, zero when down.
   assign at_bound     = up_down ? (count == MAX_V) : (count == '0);
   assign tc           = en & ~load & at_bound;
   assign load_clamped = (32'(load_value) > MAX_COUNT) ? MAX_V : load_value;

   // NOTE: every output of a combinational block gets a default first so no
   // path through the if/else leaves it unassigned and infers a latch.
   always_comb begin
      count_d = count;
      ovf_d   = 1'b0;
      if (load) begin
         count_d = load_clamped;
      end else if (en) begin
         count_d = WIDTH'(next_count(32'(count), up_down, MAX_COUNT, SAT_ON));
         ovf_d   = at_bound;
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops sample
   // their inputs from before the edge, independent of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
         ovf   <= 1'b0;
      end else begin
         count <= count_d;
         ovf   <= ovf_d;
      end
   end

endmodule

// File: tb/tb_param_updown_counter.sv
// Randomised and directed bench for param_updown_counter: wrap, saturate and
// zero-modulus instances share stimulus and are checked against a modulo model.
module tb_param_updown_counter;

   localparam int MAXC = 9;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       en;
   logic       up_down;
   logic       load;
   logic [3:0] load_value;

   logic [3:0] count_w, count_s;
   logic [2:0] count_z;
   logic       tc_w, tc_s, tc_z;
   logic       ovf_w, ovf_s, ovf_z;

   int n_vec = 0;
   int n_err = 0;

   // reference state: wrap, saturate, zero-modulus
   int m_w, m_s;
   bit o_w, o_s, o_z;

   always #5 clk = ~clk;

   param_updown_counter #(.WIDTH(4), .MAX_COUNT(MAXC), .SATURATE(1'b0)) dut_w (
      .clk(clk), .reset_n(reset_n), .en(en), .up_down(up_down), .load(load),
      .load_value(load_value), .count(count_w), .tc(tc_w), .ovf(ovf_w));

   param_updown_counter #(.WIDTH(4), .MAX_COUNT(MAXC), .SATURATE(1'b1)) dut_s (
      .clk(clk), .reset_n(reset_n), .en(en), .up_down(up_down), .load(load),
      .load_value(load_value), .count(count_s), .tc(tc_s), .ovf(ovf_s));

   param_updown_counter #(.WIDTH(3), .MAX_COUNT(0), .SATURATE(1'b0)) dut_z (
      .clk(clk), .reset_n(reset_n), .en(en), .up_down(up_down), .load(load),
      .load_value(load_value[2:0]), .count(count_z), .tc(tc_z), .ovf(ovf_z));

   function automatic bit exp_tc(int m, int maxc);
      return en && !load && ((up_down && m == maxc) || (!up_down && m == 0));
   endfunction

   // Behavioural update at one rising edge, straight from the counting rules.
   task automatic model_edge();
      if (!reset_n) begin
         m_w = 0; m_s = 0; o_w = 0; o_s = 0; o_z = 0;
      end else if (load) begin
         m_w = (load_value > MAXC) ? MAXC : int'(load_value);
         m_s = m_w;
         o_w = 0; o_s = 0; o_z = 0;
      end else if (en) begin
         o_z = 1;
         if (up_down) begin
            o_w = (m_w == MAXC);
            m_w = (m_w + 1) % (MAXC + 1);
            o_s = (m_s == MAXC);
            m_s = (m_s < MAXC) ? m_s + 1 : MAXC;
         end else begin
            o_w = (m_w == 0);
            m_w = (m_w + MAXC) % (MAXC + 1);
            o_s = (m_s == 0);
            m_s = (m_s > 0) ? m_s - 1 : 0;
         end
      end else begin
         o_w = 0; o_s = 0; o_z = 0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic drive(input bit e, input bit u, input bit l, input int v);
      en = e; up_down = u; load = l; load_value = 4'(v);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      drive(1, 1, 0, 0);
      m_w = 0; m_s = 0; o_w = 0; o_s = 0; o_z = 0;
      #2;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_vec++;
         if (count_w !== 4'd0 || ovf_w !== 1'b0 || count_s !== 4'd0 || ovf_s !== 1'b0) begin
            n_err++;
            $display("FAIL reset_hold edge %0d: count_w=%0d ovf_w=%0b count_s=%0d ovf_s=%0b, want 0/0",
                     i, count_w, ovf_w, count_s, ovf_s);
         end
      end
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      n_vec++;
      if (count_w !== 4'd1 || ovf_w !== 1'b0) begin
         n_err++;
         $display("FAIL reset_first_edge: count=%0d ovf=%0b, want 1/0", count_w, ovf_w);
      end
   endtask

   task automatic test_up_wrap();
      drive(1, 1, 1, 0);
      tick();
      drive(1, 1, 0, 0);
      for (int i = 0; i < 12; i++) begin
         #1;
         n_vec++;
         if (tc_w !== exp_tc(m_w, MAXC)) begin
            n_err++;
            $display("FAIL up_wrap_tc at count %0d: tc=%0b, want %0b", m_w, tc_w, exp_tc(m_w, MAXC));
         end
         tick();
         n_vec++;
         if (count_w !== 4'(m_w) || ovf_w !== o_w) begin
            n_err++;
            $display("FAIL up_wrap step %0d: count=%0d ovf=%0b, want %0d/%0b", i, count_w, ovf_w, m_w, o_w);
         end
      end
   endtask

   task automatic test_down_wrap();
      drive(0, 0, 1, 2);
      tick();
      drive(1, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         #1;
         n_vec++;
         if (tc_w !== exp_tc(m_w, MAXC)) begin
            n_err++;
            $display("FAIL down_wrap_tc at count %0d: tc=%0b, want %0b", m_w, tc_w, exp_tc(m_w, MAXC));
         end
         tick();
         n_vec++;
         if (count_w !== 4'(m_w) || ovf_w !== o_w) begin
            n_err++;
            $display("FAIL down_wrap step %0d: count=%0d ovf=%0b, want %0d/%0b", i, count_w, ovf_w, m_w, o_w);
         end
      end
   endtask

   task automatic test_saturate();
      drive(0, 1, 1, 7);
      tick();
      drive(1, 1, 0, 0);
      for (int i = 0; i < 5; i++) begin
         #1;
         n_vec++;
         if (tc_s !== exp_tc(m_s, MAXC)) begin
            n_err++;
            $display("FAIL sat_up_tc at count %0d: tc=%0b, want %0b", m_s, tc_s, exp_tc(m_s, MAXC));
         end
         tick();
         n_vec++;
         if (count_s !== 4'(m_s) || ovf_s !== o_s) begin
            n_err++;
            $display("FAIL sat_up step %0d: count=%0d ovf=%0b, want %0d/%0b", i, count_s, ovf_s, m_s, o_s);
         end
      end
      drive(0, 0, 1, 1);
      tick();
      drive(1, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         n_vec++;
         if (count_s !== 4'(m_s) || ovf_s !== o_s) begin
            n_err++;
            $display("FAIL sat_down step %0d: count=%0d ovf=%0b, want %0d/%0b", i, count_s, ovf_s, m_s, o_s);
         end
      end
   endtask

   task automatic test_load_priority();
      drive(1, 1, 1, 13);
      tick();
      n_vec++;
      if (count_w !== 4'd9 || ovf_w !== 1'b0) begin
         n_err++;
         $display("FAIL load_clamp: count=%0d ovf=%0b, want 9/0", count_w, ovf_w);
      end
      // At the top bound with en and up high, a load must suppress tc.
      drive(1, 1, 1, 3);
      #1;
      n_vec++;
      if (tc_w !== 1'b0) begin
         n_err++;
         $display("FAIL load_masks_tc: tc=%0b, want 0", tc_w);
      end
      tick();
      n_vec++;
      if (count_w !== 4'd3 || ovf_w !== 1'b0) begin
         n_err++;
         $display("FAIL load_over_wrap: count=%0d ovf=%0b, want 3/0", count_w, ovf_w);
      end
      drive(0, 1, 1, 5);
      tick();
      drive(0, 0, 0, 12);
      for (int i = 0; i < 5; i++) begin
         if (i > 0) tick();
         n_vec++;
         if (count_w !== 4'd5 || ovf_w !== 1'b0 || count_w !== 4'(m_w)) begin
            n_err++;
            $display("FAIL load_hold %0d: count=%0d ovf=%0b, want 5/0", i, count_w, ovf_w);
         end
      end
   endtask

   task automatic test_direction_async();
      drive(0, 1, 1, 4);
      tick();
      for (int i = 0; i < 4; i++) begin
         drive(1, (i % 2) == 0, 0, 0);
         tick();
         n_vec++;
         if (count_w !== 4'(m_w)) begin
            n_err++;
            $display("FAIL direction step %0d: count=%0d, want %0d", i, count_w, m_w);
         end
      end
      // Arrange a live ovf pulse, then reset mid-cycle: both must clear at once.
      drive(0, 1, 1, 9);
      tick();
      drive(1, 1, 0, 0);
      tick();
      #2;
      reset_n = 1'b0;
      #1;
      m_w = 0; m_s = 0; o_w = 0; o_s = 0; o_z = 0;
      n_vec++;
      if (count_w !== 4'd0 || ovf_w !== 1'b0 || count_s !== 4'd0) begin
         n_err++;
         $display("FAIL async_reset: count_w=%0d ovf_w=%0b count_s=%0d, want 0/0/0",
                  count_w, ovf_w, count_s);
      end
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
               $urandom_range(0, 9) == 0, $urandom_range(0, 15));
         #1;
         n_vec++;
         if (tc_w !== exp_tc(m_w, MAXC) || tc_s !== exp_tc(m_s, MAXC) || tc_z !== exp_tc(0, 0)) begin
            n_err++;
            $display("FAIL rand_tc %0d: tc w/s/z=%0b%0b%0b, want %0b%0b%0b", i, tc_w, tc_s, tc_z,
                     exp_tc(m_w, MAXC), exp_tc(m_s, MAXC), exp_tc(0, 0));
         end
         tick();
         n_vec++;
         if (count_w !== 4'(m_w) || ovf_w !== o_w || count_s !== 4'(m_s) || ovf_s !== o_s ||
             count_z !== 3'd0 || ovf_z !== o_z) begin
            n_err++;
            $display("FAIL rand_state %0d: w=%0d/%0b s=%0d/%0b z=%0d/%0b, want w=%0d/%0b s=%0d/%0b z=0/%0b",
                     i, count_w, ovf_w, count_s, ovf_s, count_z, ovf_z, m_w, o_w, m_s, o_s, o_z);
         end
      end
   endtask

   initial begin
      test_reset();
      test_up_wrap();
      test_down_wrap();
      test_saturate();
      test_load_priority();
      test_direction_async();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
